// File: rtl/i2c_tx_serializer.sv
// I2C byte transmitter: pops bytes from a TX FIFO and shifts them MSB-first onto open-drain SDA, then samples the ACK slot.
// Optional `define I2C_TX_BYTECOUNT_EN compiles in the ACKed-byte counter; without it byte_count is tied to zero.
module i2c_tx_serializer #(
  parameter int DATA_SIZE = 8
) (
  input  logic                 core_clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 fifo_empty,
  input  logic [DATA_SIZE-1:0] fifo_data,
  input  logic                 scl_fall_tick,
  input  logic                 scl_rise_tick,
  input  logic                 sda_in,
  output logic                 fifo_rd_en,
  output logic                 sda_oe,
  output logic                 busy,
  output logic                 done,
  output logic                 nack,
  output logic [7:0]           byte_count
);

  localparam int CNT_W = $clog2(DATA_SIZE + 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SHIFT,
    ACK,
    DONE
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [DATA_SIZE-1:0] shift_reg;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 ack_seen;
  logic                 ack_bit;
  logic                 fall;
  logic                 rise;

  // A rise tick coincident with a fall tick is dropped; the fall tick wins.
  assign fall = scl_fall_tick;
  assign rise = scl_rise_tick & ~scl_fall_tick;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (start && !fifo_empty) state_next = FETCH;
      FETCH: state_next = LOAD;
      LOAD:  state_next = SHIFT;
      SHIFT: if (fall && (bit_cnt == '0)) state_next = ACK;
      ACK:   if (fall && ack_seen) state_next = DONE;
      DONE:  state_next = (start && !fifo_empty && !nack) ? FETCH : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    fifo_rd_en = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE:    ;
      FETCH:   begin fifo_rd_en = ~fifo_empty; busy = 1'b1; end
      DONE:    begin done = 1'b1; busy = 1'b1; end
      default: busy = 1'b1;
    endcase
  end

  // Bit counter reaching zero means the LSB is already on the wire; the next fall tick releases SDA for ACK.
  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      sda_oe    <= 1'b0;
      ack_seen  <= 1'b0;
      ack_bit   <= 1'b0;
      nack      <= 1'b0;
    end else begin
      unique case (state)
        LOAD: begin
          shift_reg <= fifo_data;
          bit_cnt   <= CNT_W'(DATA_SIZE);
          ack_seen  <= 1'b0;
        end
        SHIFT: begin
          if (fall) begin
            if (bit_cnt != '0) begin
              sda_oe    <= ~shift_reg[DATA_SIZE-1];
              shift_reg <= shift_reg << 1;
              bit_cnt   <= bit_cnt - CNT_W'(1);
            end else begin
              sda_oe <= 1'b0;
            end
          end
        end
        ACK: begin
          if (rise && !ack_seen) begin
            ack_bit  <= sda_in;
            ack_seen <= 1'b1;
          end
          if (fall && ack_seen) begin
            nack <= ack_bit;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef I2C_TX_BYTECOUNT_EN
  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      byte_count <= '0;
    end else if ((state == DONE) && !nack) begin
      byte_count <= byte_count + 8'd1;
    end
  end
`else
  assign byte_count = '0;
`endif

endmodule

// File: tb/tb_i2c_tx_serializer.sv
// Directed bench for i2c_tx_serializer: table of single-byte transfers plus hand sequences for reset, NACK and tick corners.
module tb_i2c_tx_serializer;

  localparam int DW = 8;

  logic          core_clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data = '0;
  logic          scl_fall_tick = 1'b0;
  logic          scl_rise_tick = 1'b0;
  logic          sda_in = 1'b1;
  logic          fifo_rd_en;
  logic          sda_oe;
  logic          busy;
  logic          done;
  logic          nack;
  logic [7:0]    byte_count;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_bc  = 0;
  int rd_cnt  = 0;
  int done_cnt = 0;

  logic [DW-1:0] fifo_mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;

  i2c_tx_serializer #(.DATA_SIZE(DW)) dut (
    .core_clk      (core_clk),
    .rst           (rst),
    .start         (start),
    .fifo_empty    (fifo_empty),
    .fifo_data     (fifo_data),
    .scl_fall_tick (scl_fall_tick),
    .scl_rise_tick (scl_rise_tick),
    .sda_in        (sda_in),
    .fifo_rd_en    (fifo_rd_en),
    .sda_oe        (sda_oe),
    .busy          (busy),
    .done          (done),
    .nack          (nack),
    .byte_count    (byte_count)
  );

  always #5 core_clk = ~core_clk;

  // FIFO model: read data appears the cycle after the pop.
  assign fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge core_clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_data <= fifo_mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  always @(posedge core_clk) begin
    if (fifo_rd_en) rd_cnt++;
    if (done) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] bc_exp();
`ifdef I2C_TX_BYTECOUNT_EN
    return 8'(exp_bc);
`else
    return 8'd0;
`endif
  endfunction

  task automatic push(input logic [DW-1:0] d);
    fifo_mem[wr_ptr] = d;
    wr_ptr++;
  endtask

  task automatic pulse_fall();
    scl_fall_tick = 1'b1;
    @(negedge core_clk);
    scl_fall_tick = 1'b0;
  endtask

  task automatic pulse_rise(input logic v);
    sda_in = v;
    scl_rise_tick = 1'b1;
    @(negedge core_clk);
    scl_rise_tick = 1'b0;
  endtask

  task automatic wait_fetch(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge core_clk);
      if (fifo_rd_en) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Drives one full byte: 8 data fall ticks, the ACK-release fall tick, the ACK rise tick and the closing fall tick.
  task automatic run_byte(input logic ack_val, input bit coinc, output logic [7:0] oe_bits,
                          output logic oe_ack, output logic done_early, output logic done_end,
                          output logic nack_end);
    bit ok;
    wait_fetch(ok);
    check("fetch_seen", 32'(ok), 32'd1);
    repeat (2) @(negedge core_clk);
    for (int i = 0; i < 8; i++) begin
      pulse_fall();
      oe_bits[7-i] = sda_oe;
      @(negedge core_clk);
      pulse_rise(1'b1);
      @(negedge core_clk);
    end
    pulse_fall();
    oe_ack = sda_oe;
    @(negedge core_clk);
    done_early = 1'b0;
    if (coinc) begin
      sda_in = ~ack_val;
      scl_fall_tick = 1'b1;
      scl_rise_tick = 1'b1;
      @(negedge core_clk);
      scl_fall_tick = 1'b0;
      scl_rise_tick = 1'b0;
      done_early = done;
      @(negedge core_clk);
    end
    pulse_rise(ack_val);
    @(negedge core_clk);
    pulse_fall();
    done_end = done;
    nack_end = nack;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       sda_ack;
    logic [7:0] exp_oe;
    logic       exp_nack;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [7:0] oe_bits;
    logic oe_ack, done_early, done_end, nack_end;
    int rd0, dn0, viol;
    bit ok;

    vecs[0] = '{data: 8'hA5, sda_ack: 1'b0, exp_oe: 8'h5A, exp_nack: 1'b0};
    vecs[1] = '{data: 8'h3C, sda_ack: 1'b0, exp_oe: 8'hC3, exp_nack: 1'b0};
    vecs[2] = '{data: 8'hFF, sda_ack: 1'b0, exp_oe: 8'h00, exp_nack: 1'b0};
    vecs[3] = '{data: 8'h00, sda_ack: 1'b0, exp_oe: 8'hFF, exp_nack: 1'b0};
    vecs[4] = '{data: 8'h01, sda_ack: 1'b1, exp_oe: 8'hFE, exp_nack: 1'b1};

    // Reset state
    repeat (2) @(negedge core_clk);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_nack", 32'(nack), 32'd0);
    check("rst_byte_count", 32'(byte_count), 32'd0);
    rst = 1'b0;
    @(negedge core_clk);

    // start with an empty FIFO, ticks toggling: nothing may move
    rd0 = rd_cnt;
    viol = 0;
    start = 1'b1;
    for (int i = 0; i < 100; i++) begin
      scl_fall_tick = (i % 7 == 3);
      scl_rise_tick = (i % 5 == 1);
      @(negedge core_clk);
      if (fifo_rd_en || busy || sda_oe) viol++;
    end
    scl_fall_tick = 1'b0;
    scl_rise_tick = 1'b0;
    start = 1'b0;
    check("empty_start_activity", 32'(viol), 32'd0);
    check("empty_start_pops", 32'(rd_cnt - rd0), 32'd0);

    // Reset after the 4th bit of 8'h00
    dn0 = done_cnt;
    push(8'h00);
    start = 1'b1;
    wait_fetch(ok);
    check("rst_mid_fetch", 32'(ok), 32'd1);
    repeat (2) @(negedge core_clk);
    for (int i = 0; i < 4; i++) begin
      pulse_fall();
      @(negedge core_clk);
      pulse_rise(1'b1);
      @(negedge core_clk);
    end
    check("rst_mid_oe_before", 32'(sda_oe), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_oe_released", 32'(sda_oe), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    @(negedge core_clk);
    start = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge core_clk);
    check("rst_mid_no_done", 32'(done_cnt - dn0), 32'd0);
    check("rst_mid_byte_count", 32'(byte_count), 32'd0);

    // Single-byte table
    for (int v = 0; v < 5; v++) begin
      rd0 = rd_cnt;
      dn0 = done_cnt;
      push(vecs[v].data);
      start = 1'b1;
      run_byte(vecs[v].sda_ack, 1'b0, oe_bits, oe_ack, done_early, done_end, nack_end);
      start = 1'b0;
      check($sformatf("v%0d_oe_pattern", v), 32'(oe_bits), 32'(vecs[v].exp_oe));
      check($sformatf("v%0d_oe_ack_slot", v), 32'(oe_ack), 32'd0);
      check($sformatf("v%0d_done", v), 32'(done_end), 32'd1);
      check($sformatf("v%0d_nack", v), 32'(nack_end), 32'(vecs[v].exp_nack));
      if (!vecs[v].exp_nack) exp_bc++;
      @(negedge core_clk);
      check($sformatf("v%0d_done_one_cycle", v), 32'(done), 32'd0);
      check($sformatf("v%0d_byte_count", v), 32'(byte_count), 32'(bc_exp()));
      repeat (2) @(negedge core_clk);
      check($sformatf("v%0d_idle", v), 32'(busy), 32'd0);
      check($sformatf("v%0d_pops", v), 32'(rd_cnt - rd0), 32'd1);
      check($sformatf("v%0d_done_pulses", v), 32'(done_cnt - dn0), 32'd1);
    end

    // Two back-to-back bytes with start held
    rd0 = rd_cnt;
    dn0 = done_cnt;
    push(8'h3C);
    push(8'hFF);
    start = 1'b1;
    run_byte(1'b0, 1'b0, oe_bits, oe_ack, done_early, done_end, nack_end);
    check("b2b_first_oe", 32'(oe_bits), 32'hC3);
    check("b2b_first_done", 32'(done_end), 32'd1);
    run_byte(1'b0, 1'b0, oe_bits, oe_ack, done_early, done_end, nack_end);
    check("b2b_second_oe", 32'(oe_bits), 32'h00);
    check("b2b_second_done", 32'(done_end), 32'd1);
    exp_bc += 2;
    repeat (3) @(negedge core_clk);
    check("b2b_idle", 32'(busy), 32'd0);
    check("b2b_pops", 32'(rd_cnt - rd0), 32'd2);
    check("b2b_done_pulses", 32'(done_cnt - dn0), 32'd2);
    check("b2b_byte_count", 32'(byte_count), 32'(bc_exp()));
    start = 1'b0;

    // NACK on the first of two queued bytes: the second stays in the FIFO
    rd0 = rd_cnt;
    push(8'h01);
    push(8'h02);
    start = 1'b1;
    run_byte(1'b1, 1'b0, oe_bits, oe_ack, done_early, done_end, nack_end);
    start = 1'b0;
    check("nack_done", 32'(done_end), 32'd1);
    check("nack_flag", 32'(nack_end), 32'd1);
    repeat (10) @(negedge core_clk);
    check("nack_idle", 32'(busy), 32'd0);
    check("nack_held", 32'(nack), 32'd1);
    check("nack_single_pop", 32'(rd_cnt - rd0), 32'd1);
    check("nack_fifo_left", 32'(wr_ptr - rd_ptr), 32'd1);
    check("nack_byte_count", 32'(byte_count), 32'(bc_exp()));

    // Restart after NACK; coincident ticks in the ACK slot must not sample or finish
    start = 1'b1;
    run_byte(1'b0, 1'b1, oe_bits, oe_ack, done_early, done_end, nack_end);
    start = 1'b0;
    exp_bc++;
    check("coinc_oe_pattern", 32'(oe_bits), 32'hFD);
    check("coinc_no_early_done", 32'(done_early), 32'd0);
    check("coinc_done", 32'(done_end), 32'd1);
    check("coinc_rise_ignored", 32'(nack_end), 32'd0);
    @(negedge core_clk);
    check("coinc_byte_count", 32'(byte_count), 32'(bc_exp()));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_tx_serializer.md
I2C_TX_SERIALIZER -- requirements
Module: i2c_tx_serializer

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 8, giving the byte width shifted per transfer.
REQ-002 SHALL have ports: core_clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: start  in  1  level request to transmit bytes from TX FIFO.
REQ-005 SHALL have ports: fifo_empty  in  1  TX FIFO read-side empty flag.
REQ-006 SHALL have ports: fifo_data  in  DATA_SIZE  TX FIFO read data, valid the cycle after fifo_rd_en.
REQ-007 SHALL have ports: scl_fall_tick  in  1  one-cycle strobe, SCL falling edge from clock generator.
REQ-008 SHALL have ports: scl_rise_tick  in  1  one-cycle strobe, SCL rising edge.
REQ-009 SHALL have ports: sda_in  in  1  sampled SDA line level.
REQ-010 SHALL have ports: fifo_rd_en  out  1  one-cycle TX FIFO pop.
REQ-011 SHALL have ports: sda_oe  out  1  1 = pull SDA low (open drain); 0 = release.
REQ-012 SHALL have ports: busy  out  1  high in any state other than IDLE.
REQ-013 SHALL have ports: done  out  1  one-cycle pulse at end of each byte incl. ACK slot.
REQ-014 SHALL have ports: nack  out  1  ACK-slot SDA sample of last byte, held until next done.
REQ-015 SHALL have ports: byte_count  out  8  count of ACKed bytes since reset.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, LOAD, SHIFT, ACK, DONE.
REQ-017 IDLE -> FETCH when start=1 and fifo_empty=0; fifo_rd_en=1 for exactly the FETCH cycle.
REQ-018 start=1 with fifo_empty=1 SHALL stay in IDLE, fifo_rd_en=0, no SDA activity.
REQ-019 FETCH -> LOAD unconditionally; LOAD captures fifo_data into shift register, bit counter = DATA_SIZE, -> SHIFT.
REQ-020 SHIFT: on each scl_fall_tick, sda_oe = inverted current MSB, shift left, decrement counter; SDA never changes except on scl_fall_tick.
REQ-021 SHIFT -> ACK on the scl_fall_tick after the last (LSB) bit was presented; that tick sets sda_oe=0.
REQ-022 ACK: sample sda_in on first scl_rise_tick into nack; -> DONE on following scl_fall_tick.
REQ-023 DONE lasts one cycle, done=1; -> FETCH if start=1, fifo_empty=0, nack=0; else -> IDLE.
REQ-024 NACK (nack=1) SHALL return to IDLE regardless of start; next byte requires start low-then-high not required, only FIFO non-empty and start=1.
REQ-025 Coincident scl_fall_tick and scl_rise_tick: fall tick processed, rise tick ignored.
REQ-026 Ticks in IDLE, FETCH, LOAD, DONE SHALL be ignored.
REQ-027 fifo_rd_en SHALL never assert when fifo_empty=1 in that cycle.
REQ-028 byte_count increments by 1 in DONE when nack=0; wraps 255 -> 0.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, sda_oe=0, fifo_rd_en=0, busy=0, done=0, nack=0, byte_count=0, shift register=0, counter=0.
REQ-030 Reset mid-byte SHALL release SDA same cycle, abandon partial byte, no done pulse.

Configuration
REQ-031 Macro I2C_TX_BYTECOUNT_EN defined: byte_count counter per REQ-028 compiled in.
REQ-032 Macro I2C_TX_BYTECOUNT_EN undefined: no counter logic; byte_count tied to 0; all else unchanged.

Verification
REQ-033 FIFO holds 8'hA5, start=1, ACK (sda_in=0) -> one fifo_rd_en, sda_oe sequence 0,1,0,1,1,0,1,0 on fall ticks, done pulse, nack=0, byte_count=1.
REQ-034 start=1, fifo_empty=1 for 100 cycles -> fifo_rd_en=0, busy=0, sda_oe=0.
REQ-035 FIFO 8'h3C,8'hFF, start held, both ACK -> two fifo_rd_en, two done pulses, byte_count=2, back to IDLE.
REQ-036 FIFO 8'h01,8'h02, first byte NACK (sda_in=1) -> nack=1, IDLE after first done, second byte not popped.
REQ-037 rst asserted after 4th bit of 8'h00 -> sda_oe=0 same cycle, no done, byte_count unchanged at 0.
REQ-038 Build without I2C_TX_BYTECOUNT_EN, rerun REQ-035 -> byte_count=0 throughout, other outputs identical.
